// File: rtl/pdm_pkg.sv
// Shared constants, accumulator type and saturation helper for the PDM
// modulator and the decimation FIR chain.
package pdm_pkg;

  localparam int unsigned PDM_WIDTH = 16;
  localparam int unsigned PDM_ACC_W = 22;
  localparam int unsigned PDM_OSR   = 64;

  typedef logic signed [PDM_ACC_W-1:0] acc_t;

  localparam int unsigned SAT_W = 64;

  // Clamp a wide signed value to the range of a w-bit signed integer.
  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] x,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pdm_modulator_sd2_core.sv
// Second-order sigma-delta loop: two saturating integrators and a sign
// comparator, advancing once per enable tick.
module sd2_core
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH = PDM_WIDTH,
  parameter int unsigned ACC_W = PDM_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] sample,
  output logic                    pdm_out
);

  // Two guard bits keep the unsaturated sums from wrapping.
  localparam int unsigned SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] FS = SUM_W'(1) <<< (WIDTH - 1);

  logic signed [ACC_W-1:0] r_acc1;
  logic signed [ACC_W-1:0] r_acc2;
  logic                    r_pdm;

  logic signed [SUM_W-1:0] w_s;
  logic signed [SUM_W-1:0] w_fb;
  logic signed [SUM_W-1:0] w_sum1;
  logic signed [SUM_W-1:0] w_sum2;
  logic signed [ACC_W-1:0] w_a1;
  logic signed [ACC_W-1:0] w_a2;

  assign w_s    = SUM_W'(sample);
  assign w_fb   = r_pdm ? FS : -FS;
  assign w_sum1 = SUM_W'(r_acc1) + w_s - w_fb;
  assign w_a1   = ACC_W'(sat_clamp(SAT_W'(w_sum1), ACC_W));
  assign w_sum2 = SUM_W'(r_acc2) + SUM_W'(w_a1) - w_fb;
  assign w_a2   = ACC_W'(sat_clamp(SAT_W'(w_sum2), ACC_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc1 <= '0;
      r_acc2 <= '0;
      r_pdm  <= 1'b0;
    end else if (enable) begin
      r_acc1 <= w_a1;
      r_acc2 <= w_a2;
      r_pdm  <= ~w_a2[ACC_W-1];
    end
  end

  assign pdm_out = r_pdm;

endmodule

// File: rtl/pdm_modulator.sv
// PDM transmit modulator: one-entry skid buffer, per-sample tick counter and
// underflow flagging around a second-order sigma-delta core.
module pdm_modulator
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH = PDM_WIDTH,
  parameter int unsigned ACC_W = PDM_ACC_W,
  parameter int unsigned OSR   = PDM_OSR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    pdm_out,
  output logic                    pdm_valid,
  output logic                    underflow
);

  localparam int unsigned CNT_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [CNT_W-1:0]        r_cnt;
  logic                    r_buf_full;
  logic signed [WIDTH-1:0] r_buf;
  logic signed [WIDTH-1:0] r_active;
  logic                    r_pdm_valid;
  logic                    r_underflow;

  logic w_xfer;
  logic w_bnd;

  assign ready_out = ~r_buf_full;
  assign w_xfer    = valid_in & ~r_buf_full;
  assign w_bnd     = enable & (r_cnt == CNT_W'(OSR - 1));

  // A boundary with a full buffer consumes it; ready is low then, so a
  // transfer can only land in an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_buf_full  <= 1'b0;
      r_buf       <= '0;
      r_active    <= '0;
      r_pdm_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pdm_valid <= enable;
      r_underflow <= w_bnd & ~r_buf_full;
      if (enable) begin
        r_cnt <= w_bnd ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_bnd && r_buf_full) begin
        r_active   <= r_buf;
        r_buf_full <= 1'b0;
      end else if (w_xfer) begin
        r_buf      <= data_in;
        r_buf_full <= 1'b1;
      end
    end
  end

  sd2_core #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .sample  (r_active),
    .pdm_out (pdm_out)
  );

  assign pdm_valid = r_pdm_valid;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: arithmetic reference model checked
// every cycle, plus directed density, handshake, underflow and reset cases.
module tb_pdm_modulator;

  localparam int WIDTH = 16;
  localparam int ACC_W = 22;
  localparam int OSR   = 64;
  localparam longint FS   = 64'sd32768;
  localparam longint AMAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint AMIN = -AMAX - 64'sd1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic signed [WIDTH-1:0] data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic                    pdm_out;
  logic                    pdm_valid;
  logic                    underflow;

  pdm_modulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .OSR(OSR)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .pdm_out   (pdm_out),
    .pdm_valid (pdm_valid),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a1;
    longint a2;
    int     active;
    int     bufv;
    int     cnt;
    bit     pdm;
    bit     pv;
    bit     uf;
    bit     full;
  } mstate_t;

  mstate_t m;
  int      n_checks = 0;
  int      n_fail   = 0;
  bit      chk_on   = 0;
  bit      bits[$];
  bit      ref_bits[$];
  int      uf_cnt   = 0;
  bit      saw_full = 0;

  function automatic longint clampv(longint x);
    if (x > AMAX) return AMAX;
    if (x < AMIN) return AMIN;
    return x;
  endfunction

  // Reference: sample stream held per OSR ticks, loop arithmetic on plain integers.
  function automatic mstate_t next_st(mstate_t s, bit r, bit en, bit v, int d);
    mstate_t n;
    longint  fb;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.pv = en;
    n.uf = 1'b0;
    if (en) begin
      fb   = s.pdm ? FS : -FS;
      n.a1 = clampv(s.a1 + longint'(s.active) - fb);
      n.a2 = clampv(s.a2 + n.a1 - fb);
      n.pdm = (n.a2 >= 0);
      if (s.cnt == OSR - 1) begin
        n.cnt = 0;
        if (s.full) begin
          n.active = s.bufv;
          n.full   = 1'b0;
        end else begin
          n.uf = 1'b1;
        end
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    if (v && !s.full) begin
      n.bufv = d;
      n.full = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= next_st(m, rst, enable, valid_in, int'(data_in));

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("pdm_out",   pdm_out,   m.pdm);
      check("pdm_valid", pdm_valid, m.pv);
      check("underflow", underflow, m.uf);
      check("ready_out", ready_out, !m.full);
    end
  end

  // Apply inputs for one clock, then sample the outputs that edge produced.
  task automatic cycle(input bit en, input bit v, input logic signed [WIDTH-1:0] d);
    enable   = en;
    valid_in = v;
    data_in  = d;
    @(negedge clk);
    if (pdm_valid === 1'b1) bits.push_back(pdm_out);
    if (underflow === 1'b1) uf_cnt++;
    if (ready_out === 1'b0) saw_full = 1'b1;
  endtask

  task automatic clr_stats();
    bits.delete();
    uf_cnt   = 0;
    saw_full = 1'b0;
  endtask

  task automatic do_reset(input int n, input bit en);
    rst = 1'b1;
    repeat (n) cycle(en, 1'b1, 16'sd12345);
    rst = 1'b0;
    check("rst_pdm_out",   pdm_out,   0);
    check("rst_pdm_valid", pdm_valid, 0);
    check("rst_underflow", underflow, 0);
    check("rst_ready_out", ready_out, 1);
  endtask

  task automatic stream(input int nticks, input int period, input bit v,
                        input logic signed [WIDTH-1:0] d);
    int k;
    int t;
    k = 0;
    t = 0;
    while (t < nticks) begin
      cycle((k % period) == 0, v, d);
      if ((k % period) == 0) t++;
      k++;
    end
    cycle(1'b0, v, d);
  endtask

  function automatic int count_ones(input int lo, input int hi);
    int c;
    c = 0;
    for (int i = lo; i < hi && i < bits.size(); i++) c += int'(bits[i]);
    return c;
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[3];
    int idx;
    int k;
    int ticks;
    int mm;
    bit en;
    bit v;
    bit rdy;

    rst      = 1'b1;
    enable   = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    @(negedge clk);

    // Zero input from reset
    do_reset(3, 1'b0);
    chk_on = 1'b1;
    clr_stats();
    stream(1024, 2, 1'b1, '0);
    check("t1_ticks", bits.size(), 1024);
    check("t1_bit0", bits[0], 1);
    check("t1_bit1", bits[1], 1);
    check("t1_bit2", bits[2], 0);
    check("t1_bit3", bits[3], 1);
    check_range("t1_ones", count_ones(0, 1024), 510, 514);

    // Half-scale positive, continuous feed
    do_reset(3, 1'b1);
    clr_stats();
    stream(1200, 2, 1'b1, 16'sd16384);
    check_range("t2_ones", count_ones(128, 1152), 764, 772);
    check("t2_underflows", uf_cnt, 0);
    check("t2_saw_ready_low", saw_full, 1);
    ref_bits.delete();
    for (int i = 0; i < 256; i++) ref_bits.push_back(bits[i]);

    // Full-scale negative with back-to-back enables
    do_reset(3, 1'b1);
    clr_stats();
    stream(1200, 1, 1'b1, 16'sh8000);
    check_range("t3_ones", count_ones(128, 1152), 0, 10);
    check("t3_underflows", uf_cnt, 0);
    check("t3_buf_full", ready_out, 0);

    // Mid-stream reset with buffer full, then bit-exact restart
    do_reset(1, 1'b1);
    clr_stats();
    stream(256, 2, 1'b1, 16'sd16384);
    mm = 0;
    for (int i = 0; i < 256; i++) if (bits[i] != ref_bits[i]) mm++;
    check("t5_restart_mismatch", mm, 0);

    // Three samples then starve; late sample on a boundary cycle
    do_reset(3, 1'b0);
    clr_stats();
    seq[0] = 1000;
    seq[1] = -2000;
    seq[2] = 3000;
    idx    = 0;
    k      = 0;
    ticks  = 0;
    while (ticks < 450) begin
      en  = (k % 2) == 0;
      v   = idx < 3;
      rdy = ready_out;
      cycle(en, v, v ? WIDTH'(seq[idx]) : '0);
      if (v && rdy) idx++;
      if (en) ticks++;
      k++;
    end
    cycle(1'b0, 1'b0, '0);
    check("t4_accepted", idx, 3);
    check("t4_underflows", uf_cnt, 4);
    while (ticks < 576) begin
      en = (k % 2) == 0;
      v  = en && (ticks == 511);
      cycle(en, v, 16'sd5000);
      if (v) begin
        check("t4_bnd_xfer_uf", underflow, 1);
        check("t4_bnd_xfer_full", ready_out, 0);
      end
      if (en) ticks++;
      k++;
    end
    cycle(1'b0, 1'b0, '0);
    check("t4_underflows_late", uf_cnt, 5);
    check("t4_buf_drained", ready_out, 1);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
